mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- ADDR_W, 32, address width.
- DATA_W, 64, data width.
- MEM_LAT, 1, memory read latency in cycles (>=1).

REQ-002 Ports (name, direction, width, meaning), SHALL be:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  instruction-fetch read request; held high until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data.
- if_done  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data.
- d_done  out  1  one-cycle data completion pulse.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  transaction in progress (state != IDLE).
- owner  out  1  current or last grantee: 0 = IF, 1 = D.

Function
REQ-003 FSM states SHALL be IDLE, ACCESS, WAIT, RESP.
REQ-004 In IDLE with any request high, the block SHALL grant one requester and move to ACCESS next cycle. It SHALL stay in IDLE with no request.
REQ-005 On grant, the block SHALL latch the grantee's addr, we and wdata. Requester inputs SHALL be ignored until the next IDLE.
REQ-006 Arbitration SHALL be round-robin:
- Single request: grant it.
- Both requests: grant the requester that is not last_owner.
- last_owner and owner SHALL update at grant.
REQ-007 ACCESS SHALL last exactly 1 cycle:
- mem_addr = latched addr.
- mem_re = !we, mem_we = we.
- mem_wdata = latched wdata (0 for reads).
REQ-008 Outside ACCESS, mem_re = mem_we = 0. mem_addr and mem_wdata SHALL hold their last values.
REQ-009 WAIT SHALL last exactly MEM_LAT cycles, timed by a down-counter, for both loads and stores.
REQ-010 On the last WAIT cycle of a read, mem_rdata SHALL be registered into the grantee's rdata output. The other requester's rdata SHALL be unchanged.
- Store: rdata outputs unchanged.
REQ-011 RESP SHALL last 1 cycle:
- Grantee's done = 1; all other cycles done = 0.
- Next state IDLE.
- Request inputs sampled in RESP SHALL be ignored.
REQ-012 Latency SHALL be fixed. With the request first seen in IDLE at cycle 0: ACCESS in cycle 1, done in cycle 2+MEM_LAT.
REQ-013 A request still high in the IDLE cycle after done SHALL be treated as a new request. Back-to-back throughput SHALL be one transaction per 3+MEM_LAT cycles.
REQ-014 if_done and d_done SHALL never be high in the same cycle. mem_re and mem_we SHALL never be high in the same cycle.
REQ-015 Data SHALL pass unmodified. No address alignment checks or translation SHALL be performed.
REQ-016 busy SHALL be 1 in ACCESS, WAIT and RESP, and 0 in IDLE.

Reset
REQ-017 With rst high at a rising edge, the next cycle SHALL have:
- state IDLE, last_owner = 1 (so IF wins the first tie).
- owner = 0, busy = 0, if_done = d_done = 0, mem_re = mem_we = 0.
- mem_addr, mem_wdata, if_rdata, d_rdata all 0.
REQ-018 Reset during ACCESS, WAIT or RESP SHALL abort the transaction with no done pulse. The aborted requester SHALL re-arbitrate normally after reset deasserts.
REQ-019 rst SHALL take priority over all requests in the same cycle.

Verification
REQ-020 Directed scenarios (stimulus -> required response):
- MEM_LAT=1; if_req, if_addr=0x100, memory returns 0x00000000_00A00093 -> mem_re in cycle 1, if_done in cycle 3, if_rdata=0x00000000_00A00093, d_done stays 0.
- Store: d_req, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF_12345678 -> one mem_we pulse, mem_addr=0x200, mem_wdata=0xDEADBEEF_12345678, d_done in cycle 3, d_rdata unchanged.
- Both requests high from reset, held continuously, addr 0x0/0x8 -> grants alternate IF, D, IF, D; dones 4 cycles apart; no overlapping strobes.
- MEM_LAT=3 load from 0x10 -> WAIT lasts 3 cycles, d_done in cycle 5, rdata captured in cycle 4.
- rst pulsed in the first WAIT cycle of a fetch -> no if_done, busy=0 next cycle; re-issued fetch completes with the full latency.
- d_req arrives while a fetch is in WAIT -> D granted in the IDLE after the fetch's RESP, not before; if_rdata preserved.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction fetch and data ports share one memory
// port with round-robin arbitration and fixed-latency transactions.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    state_t           state;
    logic             last_owner;
    logic             lat_we;
    logic [CNT_W-1:0] cnt;
    logic             grant_d;
    logic             grant_we;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        grant_d  = (if_req && d_req) ? !last_owner : d_req;
        grant_we = grant_d && d_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            if_done    <= 1'b0;
            d_done     <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        // Strobes are registered here so they appear exactly in ACCESS.
                        state      <= ACCESS;
                        busy       <= 1'b1;
                        owner      <= grant_d;
                        last_owner <= grant_d;
                        lat_we     <= grant_we;
                        mem_addr   <= grant_d ? d_addr : if_addr;
                        mem_wdata  <= grant_we ? d_wdata : '0;
                        mem_re     <= !grant_we;
                        mem_we     <= grant_we;
                    end
                end
                ACCESS: begin
                    state <= WAIT;
                    cnt   <= CNT_INIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                        if (owner) begin
                            d_done <= 1'b1;
                            if (!lat_we) d_rdata <= mem_rdata;
                        end else begin
                            if_done <= 1'b1;
                            if (!lat_we) if_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
